// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer
// Collects a three-byte command (operand A, operand B, opcode) from the UART
// receiver and holds it in registers that drive the ALU. It then captures the
// (OPERAND_SIZE+1)-bit ALU result and returns it as two bytes through the
// UART transmitter: the low byte first, then a byte carrying the carry/borrow
// bit in bit 0.
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_rx_data        received byte, qualified by the i_rx_done pulse
//   i_tx_done        pulse: transmitter finished the current byte
//   i_alu_result     combinational ALU result
//   o_dato_a/b       registered ALU operands
//   o_op_code        registered ALU opcode
//   o_tx_data        registered byte for the transmitter
//   o_tx_start       pulse: start transmitting o_tx_data
//   o_busy           high whenever not waiting for operand A
//   o_timeout        pulse: a partial command was discarded
module alu_uart_sequencer #(
    parameter int unsigned OPERAND_SIZE   = 8,
    parameter int unsigned OP_CODE_SIZE   = 6,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_done,
    input  logic                    i_tx_done,
    input  logic [OPERAND_SIZE:0]   i_alu_result,
    output logic [OPERAND_SIZE-1:0] o_dato_a,
    output logic [OPERAND_SIZE-1:0] o_dato_b,
    output logic [OP_CODE_SIZE-1:0] o_op_code,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_start,
    output logic                    o_busy,
    output logic                    o_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND_LO = 3'd4,
        WAIT_LO = 3'd5,
        SEND_HI = 3'd6,
        WAIT_HI = 3'd7
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [OPERAND_SIZE-1:0] r_dato_a,   w_dato_a_next;
    logic [OPERAND_SIZE-1:0] r_dato_b,   w_dato_b_next;
    logic [OP_CODE_SIZE-1:0] r_op_code,  w_op_code_next;
    logic [OPERAND_SIZE:0]   r_result,   w_result_next;
    logic [7:0]              r_tx_data,  w_tx_data_next;
    logic                    r_tx_start, w_tx_start_next;
    logic                    r_busy,     w_busy_next;
    logic                    r_timeout,  w_timeout_next;
    logic [CNT_W-1:0]        r_cnt,      w_cnt_next;

    // State and output registers; every output is a direct register copy.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= GET_A;
            r_dato_a   <= '0;
            r_dato_b   <= '0;
            r_op_code  <= '0;
            r_result   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_dato_a   <= w_dato_a_next;
            r_dato_b   <= w_dato_b_next;
            r_op_code  <= w_op_code_next;
            r_result   <= w_result_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_start <= w_tx_start_next;
            r_busy     <= w_busy_next;
            r_timeout  <= w_timeout_next;
            r_cnt      <= w_cnt_next;
        end
    end

    // Next-state and next-output logic. Registered outputs are computed from
    // the state being entered, so o_tx_start is high exactly in SEND_LO/SEND_HI.
    always_comb begin
        w_state_next    = r_state;
        w_dato_a_next   = r_dato_a;
        w_dato_b_next   = r_dato_b;
        w_op_code_next  = r_op_code;
        w_result_next   = r_result;
        w_tx_data_next  = r_tx_data;
        w_tx_start_next = 1'b0;
        w_timeout_next  = 1'b0;
        w_cnt_next      = r_cnt;

        case (r_state)
            GET_A: begin
                w_cnt_next = '0;
                if (i_rx_done) begin
                    w_dato_a_next = i_rx_data[OPERAND_SIZE-1:0];
                    w_state_next  = GET_B;
                end
            end
            GET_B: begin
                if (i_rx_done) begin
                    w_dato_b_next = i_rx_data[OPERAND_SIZE-1:0];
                    w_cnt_next    = '0;
                    w_state_next  = GET_OP;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout_next = 1'b1;
                    w_cnt_next     = '0;
                    w_state_next   = GET_A;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            GET_OP: begin
                if (i_rx_done) begin
                    w_op_code_next = i_rx_data[OP_CODE_SIZE-1:0];
                    w_cnt_next     = '0;
                    w_state_next   = EXEC;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout_next = 1'b1;
                    w_cnt_next     = '0;
                    w_state_next   = GET_A;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            EXEC: begin
                // Operands have been stable for a cycle; capture the result
                // and present the low byte together with the start pulse.
                w_result_next   = i_alu_result;
                w_tx_data_next  = 8'(i_alu_result[OPERAND_SIZE-1:0]);
                w_tx_start_next = 1'b1;
                w_state_next    = SEND_LO;
            end
            SEND_LO: begin
                w_state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (i_tx_done) begin
                    w_tx_data_next  = 8'(r_result[OPERAND_SIZE]);
                    w_tx_start_next = 1'b1;
                    w_state_next    = SEND_HI;
                end
            end
            SEND_HI: begin
                w_state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (i_tx_done) begin
                    w_state_next = GET_A;
                end
            end
            default: begin
                w_state_next = GET_A;
            end
        endcase

        w_busy_next = (w_state_next != GET_A);
    end

    assign o_dato_a   = r_dato_a;
    assign o_dato_b   = r_dato_b;
    assign o_op_code  = r_op_code;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = r_busy;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed testbench for alu_uart_sequencer with a short timeout (16 cycles).
module tb_alu_uart_sequencer;

    localparam int unsigned OS = 8;
    localparam int unsigned OC = 6;
    localparam int unsigned TO = 16;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [7:0]    i_rx_data = '0;
    logic          i_rx_done = 1'b0;
    logic          i_tx_done = 1'b0;
    logic [OS:0]   i_alu_result;
    logic [OS-1:0] o_dato_a;
    logic [OS-1:0] o_dato_b;
    logic [OC-1:0] o_op_code;
    logic [7:0]    o_tx_data;
    logic          o_tx_start;
    logic          o_busy;
    logic          o_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_to     = 0;
    logic [7:0] tx_q[$];

    alu_uart_sequencer #(
        .OPERAND_SIZE  (OS),
        .OP_CODE_SIZE  (OC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .i_tx_done   (i_tx_done),
        .i_alu_result(i_alu_result),
        .o_dato_a    (o_dato_a),
        .o_dato_b    (o_dato_b),
        .o_op_code   (o_op_code),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Stand-in ALU: ADD 0x20, SUB 0x22, AND 0x24, carry/borrow in the MSB.
    always_comb begin
        case (o_op_code)
            6'h20:   i_alu_result = {1'b0, o_dato_a} + {1'b0, o_dato_b};
            6'h22:   i_alu_result = {1'b0, o_dato_a} - {1'b0, o_dato_b};
            6'h24:   i_alu_result = {1'b0, o_dato_a & o_dato_b};
            default: i_alu_result = '0;
        endcase
    end

    // Output monitor on the falling edge.
    always @(negedge i_clk) begin
        if (o_tx_start) begin
            tx_q.push_back(o_tx_data);
            n_start = n_start + 1;
        end
        if (o_timeout) n_to = n_to + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick(1);
        i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        i_tx_done = 1'b1;
        tick(1);
        i_tx_done = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_a"},     32'(o_dato_a),   0);
        check({nm, "_b"},     32'(o_dato_b),   0);
        check({nm, "_op"},    32'(o_op_code),  0);
        check({nm, "_txd"},   32'(o_tx_data),  0);
        check({nm, "_start"}, 32'(o_tx_start), 0);
        check({nm, "_busy"},  32'(o_busy),     0);
        check({nm, "_to"},    32'(o_timeout),  0);
    endtask

    // One full command with latency and byte checks at every step.
    task automatic run_cmd(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input int exp_op, input int exp_lo,
                           input int exp_hi, input int gap_b, input int ack_dly,
                           input bit inject);
        int s;
        int s_to;
        s    = n_start;
        s_to = n_to;
        send_byte(a);
        check({nm, "_busy_b"}, 32'(o_busy), 1);
        tick(gap_b);
        send_byte(b);
        check({nm, "_to_b"}, 32'(o_timeout), 0);
        send_byte(op);
        check({nm, "_a"},  32'(o_dato_a),   32'(a));
        check({nm, "_b"},  32'(o_dato_b),   32'(b));
        check({nm, "_op"}, 32'(o_op_code),  32'(exp_op));
        check({nm, "_exec_start"}, 32'(o_tx_start), 0);
        tick(1);
        check({nm, "_lo_start"}, 32'(o_tx_start), 1);
        check({nm, "_lo_data"},  32'(o_tx_data),  32'(exp_lo));
        tick(1);
        check({nm, "_waitlo_start"}, 32'(o_tx_start), 0);
        if (inject) begin
            send_byte(8'h77);
            check({nm, "_inj_a"},     32'(o_dato_a),   32'(a));
            check({nm, "_inj_b"},     32'(o_dato_b),   32'(b));
            check({nm, "_inj_start"}, 32'(o_tx_start), 0);
            check({nm, "_inj_data"},  32'(o_tx_data),  32'(exp_lo));
        end
        tick(ack_dly);
        pulse_tx_done();
        check({nm, "_hi_start"}, 32'(o_tx_start), 1);
        check({nm, "_hi_data"},  32'(o_tx_data),  32'(exp_hi));
        tick(1);
        check({nm, "_waithi_busy"}, 32'(o_busy), 1);
        tick(ack_dly);
        pulse_tx_done();
        check({nm, "_idle_busy"}, 32'(o_busy), 0);
        check({nm, "_n_start"}, 32'(n_start - s), 2);
        check({nm, "_n_to"},    32'(n_to - s_to), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int q0;

        // Power-on reset.
        tick(2);
        check_all_zero("rst0");
        i_reset = 1'b0;
        tick(1);

        // ADD 5+3 = 0x008.
        run_cmd("add", 8'h05, 8'h03, 8'h20, 'h20, 'h08, 'h00, 0, 3, 1'b0);

        // SUB 3-5 = 0x1FE (borrow set).
        run_cmd("sub", 8'h03, 8'h05, 8'h22, 'h22, 'hFE, 'h01, 0, 2, 1'b0);

        // Opcode masking 0xE4 -> 0x24, AND 0x0F & 0x3C = 0x0C; stray byte in WAIT_LO.
        run_cmd("mask", 8'h0F, 8'h3C, 8'hE4, 'h24, 'h0C, 'h00, 0, 1, 1'b1);

        // Reset in the middle of WAIT_LO.
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        tick(2);
        check("rstmid_pre_busy", 32'(o_busy), 1);
        i_reset = 1'b1;
        tick(2);
        check_all_zero("rstmid");
        i_reset = 1'b0;
        s = n_start;
        tick(3);
        pulse_tx_done();
        tick(3);
        check("rstmid_no_start", 32'(n_start - s), 0);
        check("rstmid_busy", 32'(o_busy), 0);
        run_cmd("post_rst", 8'h21, 8'h12, 8'h20, 'h20, 'h33, 'h00, 0, 1, 1'b0);

        // Timeout after operand A only.
        s = n_to;
        send_byte(8'hAA);
        tick(TO - 1);
        check("to_early", 32'(o_timeout), 0);
        check("to_early_busy", 32'(o_busy), 1);
        tick(1);
        check("to_pulse", 32'(o_timeout), 1);
        check("to_busy", 32'(o_busy), 0);
        tick(1);
        check("to_pulse_end", 32'(o_timeout), 0);
        tick(3);
        check("to_count", 32'(n_to - s), 1);
        check("to_keep_a", 32'(o_dato_a), 'hAA);
        run_cmd("after_to", 8'h01, 8'h02, 8'h24, 'h24, 'h00, 'h00, 0, 1, 1'b0);

        // Operand B arrives exactly in the expiry cycle: accepted, no timeout.
        run_cmd("expiry", 8'h11, 8'h22, 8'h20, 'h20, 'h33, 'h00, TO - 1, 1, 1'b0);

        // Back-to-back commands with immediate tx_done.
        s  = n_start;
        q0 = tx_q.size();
        run_cmd("b2b1", 8'hFF, 8'h01, 8'h20, 'h20, 'h00, 'h01, 0, 0, 1'b0);
        run_cmd("b2b2", 8'h80, 8'h01, 8'h22, 'h22, 'h7F, 'h00, 0, 0, 1'b0);
        check("b2b_starts", 32'(n_start - s), 4);
        if (tx_q.size() >= q0 + 4) begin
            check("b2b_q0", 32'(tx_q[q0]),     'h00);
            check("b2b_q1", 32'(tx_q[q0 + 1]), 'h01);
            check("b2b_q2", 32'(tx_q[q0 + 2]), 'h7F);
            check("b2b_q3", 32'(tx_q[q0 + 3]), 'h00);
        end else begin
            check("b2b_qsize", 32'(tx_q.size() - q0), 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
